// File: rtl/maxnet_engine.sv
// maxnet_engine: self-sequencing MaxNet winner-take-all engine.
//
// Takes N signed channel values on a start strobe. It then repeats the
// lateral-inhibition update
//     val[i] <- ReLU(val[i] - eps * (sum(val) - val[i]))
// until at most one channel is still positive, or until MAX_ITER iterations
// have run. One shared multiply-subtract unit handles the channels one at a
// time: the sum takes N cycles and the update takes N cycles.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   start        begin a run (sampled only while idle)
//   din          N packed channel values, channel i at din[i*XLEN +: XLEN]
//   eps          inhibition weight, unsigned Q.FRAC, sampled with start
//   busy         high from the cycle after start is accepted through done
//   done         one-cycle completion pulse
//   valid_winner exactly one channel survived
//   winner_idx   index of the surviving (or lowest live, on timeout) channel
//   maxnumber    original din value of the winner, 0 without a winner
//   iter_count   inhibition iterations executed
//   timeout      run ended by reaching MAX_ITER
module maxnet_engine #(
    parameter int XLEN     = 32,
    parameter int N        = 4,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N*XLEN-1:0]              din,
    input  logic [XLEN-1:0]                eps,
    output logic                           busy,
    output logic                           done,
    output logic                           valid_winner,
    output logic [$clog2(N)-1:0]           winner_idx,
    output logic [XLEN-1:0]                maxnumber,
    output logic [$clog2(MAX_ITER+1)-1:0]  iter_count,
    output logic                           timeout
);

    localparam int IW  = $clog2(N);
    localparam int CW  = $clog2(N + 1);
    localparam int SW  = XLEN + $clog2(N);
    localparam int PW  = 2 * XLEN + $clog2(N) + 1;
    localparam int ITW = $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SUM,
        S_UPD,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [XLEN-1:0]      eps_q, eps_d;
    logic [XLEN-1:0]      x_q   [N];
    logic [XLEN-1:0]      x_d   [N];
    logic [XLEN-1:0]      val_q [N];
    logic [XLEN-1:0]      val_d [N];
    logic [ITW-1:0]       iter_q, iter_d;
    logic                 tmo_q, tmo_d;
    logic                 vw_q, vw_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [XLEN-1:0]      maxn_q, maxn_d;

    // Count of live channels and the lowest live index.
    logic [CW-1:0]        nz_cnt;
    logic [IW-1:0]        nz_low;

    // Shared inhibition datapath for channel ptr_q.
    logic signed [SW-1:0] diff;
    logic signed [PW-1:0] eps_ext;
    logic signed [PW-1:0] diff_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] inhib;
    logic signed [PW-1:0] upd;
    logic [XLEN-1:0]      new_val;

    always_comb begin
        nz_cnt = '0;
        nz_low = '0;
        // Scan downwards so that the last hit is the lowest live index.
        for (int unsigned i = N; i > 0; i--) begin
            if (val_q[i-1] != '0) begin
                nz_cnt = nz_cnt + CW'(1);
                nz_low = IW'(i - 1);
            end
        end
    end

    always_comb begin
        // sum_q holds only non-negative terms, so diff is never negative.
        diff     = sum_q - SW'(val_q[ptr_q]);
        eps_ext  = PW'(eps_q);
        diff_ext = PW'(diff);
        prod     = eps_ext * diff_ext;
        inhib    = prod >>> FRAC;
        upd      = PW'(val_q[ptr_q]) - inhib;
        new_val  = (!upd[PW-1] && (upd != '0)) ? upd[XLEN-1:0] : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        eps_d   = eps_q;
        x_d     = x_q;
        val_d   = val_q;
        iter_d  = iter_q;
        tmo_d   = tmo_q;
        vw_d    = vw_q;
        idx_d   = idx_q;
        maxn_d  = maxn_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        x_d[i]   = din[i*XLEN +: XLEN];
                        val_d[i] = din[i*XLEN + XLEN - 1] ? '0 : din[i*XLEN +: XLEN];
                    end
                    eps_d   = eps;
                    iter_d  = '0;
                    tmo_d   = 1'b0;
                    vw_d    = 1'b0;
                    idx_d   = '0;
                    maxn_d  = '0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (nz_cnt == CW'(1)) begin
                    vw_d    = 1'b1;
                    idx_d   = nz_low;
                    maxn_d  = x_q[nz_low];
                    state_d = S_DONE;
                end else if (nz_cnt == '0) begin
                    vw_d    = 1'b0;
                    idx_d   = '0;
                    maxn_d  = '0;
                    state_d = S_DONE;
                end else if (iter_q == ITW'(MAX_ITER)) begin
                    tmo_d   = 1'b1;
                    vw_d    = 1'b0;
                    idx_d   = nz_low;
                    maxn_d  = '0;
                    state_d = S_DONE;
                end else begin
                    sum_d   = '0;
                    ptr_d   = '0;
                    state_d = S_SUM;
                end
            end

            S_SUM: begin
                sum_d = sum_q + SW'(val_q[ptr_q]);
                if (ptr_q == IW'(N - 1)) begin
                    ptr_d   = '0;
                    state_d = S_UPD;
                end else begin
                    ptr_d = ptr_q + IW'(1);
                end
            end

            S_UPD: begin
                // Each channel is written exactly once and sum_q stays frozen
                // during this phase, so updating in place matches the
                // simultaneous update.
                val_d[ptr_q] = new_val;
                if (ptr_q == IW'(N - 1)) begin
                    ptr_d   = '0;
                    iter_d  = iter_q + ITW'(1);
                    state_d = S_CHECK;
                end else begin
                    ptr_d = ptr_q + IW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sum_q   <= '0;
            eps_q   <= '0;
            iter_q  <= '0;
            tmo_q   <= 1'b0;
            vw_q    <= 1'b0;
            idx_q   <= '0;
            maxn_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i]   <= '0;
                val_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            eps_q   <= eps_d;
            iter_q  <= iter_d;
            tmo_q   <= tmo_d;
            vw_q    <= vw_d;
            idx_q   <= idx_d;
            maxn_q  <= maxn_d;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i]   <= x_d[i];
                val_q[i] <= val_d[i];
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign valid_winner = vw_q;
    assign winner_idx   = idx_q;
    assign maxnumber    = maxn_q;
    assign iter_count   = iter_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_maxnet_engine.sv
// Testbench for maxnet_engine. Instance A has N=4 and instance B has N=8.
// A reference model works out each run's result and its done cycle directly
// from the MaxNet rules. A single compare process checks both instances on
// every cycle.
module tb_maxnet_engine;

    localparam int MAXI = 64;

    typedef struct {
        bit     valid;
        int     idx;
        longint maxn;
        int     iters;
        bit     tmo;
        int     dcyc;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         start_a = 1'b0;
    logic [127:0] din_a = '0;
    logic [31:0]  eps_a = '0;
    logic         busy_a, done_a, vw_a, tmo_a;
    logic [1:0]   idx_a;
    logic [31:0]  maxn_a;
    logic [6:0]   itc_a;

    logic         start_b = 1'b0;
    logic [255:0] din_b = '0;
    logic [31:0]  eps_b = '0;
    logic         busy_b, done_b, vw_b, tmo_b;
    logic [2:0]   idx_b;
    logic [31:0]  maxn_b;
    logic [6:0]   itc_b;

    int   n_chk  = 0;
    int   n_pass = 0;

    res_t cur [2];
    res_t nxt [2];
    bit   run [2];
    bit   arm [2];
    int   cyc [2];

    maxnet_engine #(.XLEN(32), .N(4), .FRAC(16), .MAX_ITER(MAXI)) dut_a (
        .clk(clk), .rst(rst_n), .start(start_a), .din(din_a), .eps(eps_a),
        .busy(busy_a), .done(done_a), .valid_winner(vw_a), .winner_idx(idx_a),
        .maxnumber(maxn_a), .iter_count(itc_a), .timeout(tmo_a)
    );

    maxnet_engine #(.XLEN(32), .N(8), .FRAC(16), .MAX_ITER(MAXI)) dut_b (
        .clk(clk), .rst(rst_n), .start(start_b), .din(din_b), .eps(eps_b),
        .busy(busy_b), .done(done_b), .valid_winner(vw_b), .winner_idx(idx_b),
        .maxnumber(maxn_b), .iter_count(itc_b), .timeout(tmo_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic res_t zero_res();
        res_t r;
        r.valid = 0; r.idx = 0; r.maxn = 0; r.iters = 0; r.tmo = 0; r.dcyc = 0;
        return r;
    endfunction

    // MaxNet reference: all channels update together from the previous values.
    function automatic res_t model(input int n, input int d[8], input longint e);
        res_t   r;
        longint v [8];
        longint nv [8];
        longint s;
        longint p;
        int     cnt;
        int     low;
        bit     fin;
        r = zero_res();
        for (int i = 0; i < 8; i++) v[i] = (i < n && d[i] > 0) ? longint'(d[i]) : 0;
        fin = 0;
        while (!fin) begin
            cnt = 0;
            low = -1;
            for (int i = 0; i < n; i++) begin
                if (v[i] != 0) begin
                    cnt++;
                    if (low < 0) low = i;
                end
            end
            if (cnt == 1) begin
                r.valid = 1; r.idx = low; r.maxn = d[low]; fin = 1;
            end else if (cnt == 0) begin
                fin = 1;
            end else if (r.iters == MAXI) begin
                r.tmo = 1; r.idx = low; fin = 1;
            end else begin
                s = 0;
                for (int i = 0; i < n; i++) s += v[i];
                for (int i = 0; i < n; i++) begin
                    p = (e * (s - v[i])) / 65536;
                    nv[i] = v[i] - p;
                    if (nv[i] < 0) nv[i] = 0;
                end
                for (int i = 0; i < n; i++) v[i] = nv[i];
                r.iters++;
            end
        end
        r.dcyc = 2 + r.iters * (2 * n + 1);
        return r;
    endfunction

    task automatic check_inst(input int k, input logic b, input logic dn, input logic vw,
                              input int idx, input longint mx, input int itc, input logic tmo);
        res_t  r;
        string nm;
        r  = cur[k];
        nm = (k == 0) ? "A" : "B";
        if (run[k] && cyc[k] < r.dcyc) begin
            chk($sformatf("%s busy c%0d", nm, cyc[k]), b, 1);
            chk($sformatf("%s done c%0d", nm, cyc[k]), dn, 0);
            chk($sformatf("%s valid c%0d", nm, cyc[k]), vw, 0);
            chk($sformatf("%s idx c%0d", nm, cyc[k]), idx, 0);
            chk($sformatf("%s maxnumber c%0d", nm, cyc[k]), mx, 0);
            chk($sformatf("%s timeout c%0d", nm, cyc[k]), tmo, 0);
        end else begin
            chk($sformatf("%s busy c%0d", nm, cyc[k]), b, (run[k] && cyc[k] == r.dcyc) ? 1 : 0);
            chk($sformatf("%s done c%0d", nm, cyc[k]), dn, (run[k] && cyc[k] == r.dcyc) ? 1 : 0);
            chk($sformatf("%s valid c%0d", nm, cyc[k]), vw, r.valid);
            chk($sformatf("%s idx c%0d", nm, cyc[k]), idx, r.idx);
            chk($sformatf("%s maxnumber c%0d", nm, cyc[k]), mx, r.maxn);
            chk($sformatf("%s iter_count c%0d", nm, cyc[k]), itc, r.iters);
            chk($sformatf("%s timeout c%0d", nm, cyc[k]), tmo, r.tmo);
        end
    endtask

    // Compare process: the cycle count is 1 in the cycle right after start is accepted.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                run[k] = 0; arm[k] = 0; cyc[k] = 0; cur[k] = zero_res();
            end else if (arm[k]) begin
                arm[k] = 0; run[k] = 1; cyc[k] = 1; cur[k] = nxt[k];
            end else if (run[k]) begin
                cyc[k]++;
            end
        end
        #1;
        check_inst(0, busy_a, done_a, vw_a, int'(idx_a), longint'($signed(maxn_a)), int'(itc_a), tmo_a);
        check_inst(1, busy_b, done_b, vw_b, int'(idx_b), longint'($signed(maxn_b)), int'(itc_b), tmo_b);
    end

    task automatic launch(input int k, input int d[8], input logic [31:0] e);
        @(negedge clk);
        nxt[k] = model((k == 0) ? 4 : 8, d, longint'(e));
        if (k == 0) begin
            for (int i = 0; i < 4; i++) din_a[i*32 +: 32] = d[i];
            eps_a = e;
            start_a = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) din_b[i*32 +: 32] = d[i];
            eps_b = e;
            start_b = 1'b1;
        end
        arm[k] = 1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // A start pulse that the DUT must ignore (it is busy or in its done cycle).
    task automatic stray_start_a(input int d0);
        din_a = '0;
        din_a[31:0] = d0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int lim;
        lim = cur[k].dcyc + 10;
        for (int t = 0; t < lim; t++) begin
            @(negedge clk);
            if (run[k] && cyc[k] >= cur[k].dcyc) return;
        end
        n_chk++;
        $display("FAIL wait_done inst %0d: cycle %0d, expected done by %0d", k, cyc[k], cur[k].dcyc);
    endtask

    initial begin
        int d [8];
        int mode;
        int n;
        logic [31:0] e;

        for (int k = 0; k < 2; k++) begin
            cur[k] = zero_res(); nxt[k] = zero_res(); run[k] = 0; arm[k] = 0; cyc[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Four-channel example from the description; a start in the done cycle is ignored.
        d = '{10, 20, 30, 40, 0, 0, 0, 0};
        launch(0, d, 32'h4000);
        chk("pin t1 dcyc", nxt[0].dcyc, 38);
        chk("pin t1 iters", nxt[0].iters, 4);
        chk("pin t1 idx", nxt[0].idx, 3);
        chk("pin t1 maxn", nxt[0].maxn, 40);
        wait_done(0);
        stray_start_a(100);
        repeat (2) @(negedge clk);

        d = '{0, -5, 7, 0, 0, 0, 0, 0};
        launch(0, d, 32'h4000);
        chk("pin t2 dcyc", nxt[0].dcyc, 2);
        chk("pin t2 maxn", nxt[0].maxn, 7);
        chk("pin t2 idx", nxt[0].idx, 2);
        wait_done(0);

        d = '{-1, 0, -9, 0, 0, 0, 0, 0};
        launch(0, d, 32'h4000);
        chk("pin t3 valid", nxt[0].valid, 0);
        chk("pin t3 dcyc", nxt[0].dcyc, 2);
        wait_done(0);

        d = '{5, 5, 0, 0, 0, 0, 0, 0};
        launch(0, d, 32'h4000);
        chk("pin t4 dcyc", nxt[0].dcyc, 578);
        chk("pin t4 tmo", nxt[0].tmo, 1);
        chk("pin t4 iters", nxt[0].iters, 64);
        chk("pin t4 idx", nxt[0].idx, 0);
        wait_done(0);

        // Start pulses while busy must not disturb the run.
        d = '{10, 20, 30, 40, 0, 0, 0, 0};
        launch(0, d, 32'h4000);
        repeat (3) @(negedge clk);
        stray_start_a(500);
        repeat (6) @(negedge clk);
        stray_start_a(-7);
        wait_done(0);

        // Reset in the UPD phase of the second iteration, then rerun.
        launch(0, d, 32'h4000);
        for (int t = 0; t < 40 && cyc[0] < 16; t++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst busy", busy_a, 0);
        chk("rst done", done_a, 0);
        chk("rst valid", vw_a, 0);
        chk("rst idx", idx_a, 0);
        chk("rst maxnumber", maxn_a, 0);
        chk("rst iter_count", itc_a, 0);
        chk("rst timeout", tmo_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(0, d, 32'h4000);
        wait_done(0);

        // Eight-channel instance.
        for (int i = 0; i < 8; i++) d[i] = (i + 1) * 1000;
        launch(1, d, 32'h1000);
        chk("pin b1 valid", nxt[1].valid, 1);
        chk("pin b1 idx", nxt[1].idx, 7);
        chk("pin b1 maxn", nxt[1].maxn, 8000);
        wait_done(1);
        for (int i = 0; i < 8; i++) d[i] = i + 1;
        launch(1, d, 32'h1000);
        wait_done(1);

        // Randomised runs on both instances.
        for (int r = 0; r < 22; r++) begin
            int k;
            k = (r < 16) ? 0 : 1;
            n = (k == 0) ? 4 : 8;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    0: d[i] = int'($urandom());
                    1: d[i] = int'($urandom_range(0, 250)) - 50;
                    default: d[i] = int'($urandom_range(0, 100000));
                endcase
            end
            e = 32'($urandom_range(1, (65536 / (n - 1)) - 1));
            launch(k, d, e);
            wait_done(k);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
